// File: rtl/uncache_pkg.sv
// Shared definitions for the uncached AXI bridge:
//   uc_state_e          - bridge FSM states
//   SZ_BYTE/HALF/WORD   - request size encodings
//   AXI_RESP_OKAY       - AXI response code for success
//   AXI_BURST_INCR      - AXI incrementing burst type
//   axi_size()          - maps a request size onto AxSIZE
package uncache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } uc_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Size code 3 has no wider meaning on a 32-bit bus; issue it as a word.
  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return (sz == 2'd3) ? {1'b0, SZ_WORD} : {1'b0, sz};
  endfunction

endpackage

// File: rtl/uncache_axi_bridge.sv
// Single-outstanding uncached load/store engine. Accepts one request from the
// memory stage, performs one single-beat AXI4 read or write with the physical
// address unchanged, and returns a one-cycle response pulse.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_*                     request handshake and payload from memory stage
//   resp_valid/rdata/err      one-cycle completion pulse, load data, error
//   ar*/r*                    AXI4 read address / read data channels
//   aw*/w*/b*                 AXI4 write address / write data / write response
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request (req_ready high)
// RD_ADDR | arvalid held until arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | awvalid/wvalid raised together, each dropped after its handshake
// WR_RESP | bready high, waiting for bvalid
// DONE    | resp_valid pulse for one cycle
module uncache_axi_bridge
  import uncache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  uc_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wstrb_d   = req_wstrb;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wr ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != AXI_RESP_OKAY);
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // Each channel completes on its own; both may land in the same cycle.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          err_d   = (bresp != AXI_RESP_OKAY);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is registered so it reads 0 while reset is held.
  assign ready_d = (state_d == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign araddr  = addr_q;
  assign arsize  = axi_size(size_q);
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awburst = AXI_BURST_INCR;
  assign awaddr  = addr_q;
  assign awsize  = axi_size(size_q);
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign wlast   = wvalid;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_uncache_axi_bridge.sv
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0, wdata;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uncache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  // One request plus a slave that answers after the given per-channel delays.
  // Expected latency and payload come straight from the handshake rules.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] ws, input logic [31:0] wd,
                        input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                        input int b_dly, input bit b_early, input logic [31:0] rd,
                        input logic [1:0] rr, input logic [1:0] br);
    int c = 1, wait_c = 0;
    int ar_first = -1, ar_hs_c = -1, aw_hs_c = -1, w_hs_c = -1, resp_c = -1;
    int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
    int exp_lat, mx;
    bit unstable = 0, ready_bad = 0, bready_early = 0;
    logic [31:0] g_rdata = '0, g_araddr = '0, g_awaddr = '0, g_wdata = '0;
    logic [2:0]  g_arsize = '0, g_awsize = '0, exp_sz;
    logic [3:0]  g_wstrb = '0;
    logic        g_err = 0, g_wlast = 0;
    exp_sz = (size == 2'd3) ? 3'd2 : {1'b0, size};
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    exp_lat = wr ? (3 + mx + (b_early ? 0 : b_dly)) : (3 + ar_dly + r_dly);

    @(negedge clk);
    while (!req_ready && wait_c < 20) begin @(negedge clk); wait_c++; end
    check("req_ready_before", req_ready, 1);
    req_valid = 1; req_wr = wr; req_addr = addr; req_size = size; req_wstrb = ws; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;

    forever begin
      if (req_ready) ready_bad = 1;
      if (resp_valid) begin resp_c = c; g_rdata = resp_rdata; g_err = resp_err; end
      if (bready && !(aw_n > 0 && w_n > 0)) bready_early = 1;
      if (arvalid) begin
        if (ar_first < 0) begin ar_first = c; g_araddr = araddr; g_arsize = arsize; end
        else if (araddr !== g_araddr || arsize !== g_arsize) unstable = 1;
      end
      arready = (ar_first >= 0) && (c >= ar_first + ar_dly);
      if (arvalid && arready) begin ar_n++; ar_hs_c = c; end
      rvalid = (r_n == 0) && (ar_hs_c >= 0) && (c >= ar_hs_c + 1 + r_dly);
      rdata  = rvalid ? rd : $urandom;
      rresp  = rvalid ? rr : 2'($urandom);
      if (rvalid && rready) r_n++;
      awready = (c >= 1 + aw_dly);
      if (awvalid && awready) begin aw_n++; aw_hs_c = c; g_awaddr = awaddr; g_awsize = awsize; end
      wready = (c >= 1 + w_dly);
      if (wvalid && wready) begin w_n++; w_hs_c = c; g_wdata = wdata; g_wstrb = wstrb; g_wlast = wlast; end
      bvalid = wr && (b_n == 0) &&
               (b_early ? 1'b1 : (aw_n > 0 && w_n > 0 &&
                c >= ((aw_hs_c > w_hs_c) ? aw_hs_c : w_hs_c) + 1 + b_dly));
      bresp = bvalid ? br : 2'($urandom);
      if (bvalid && bready) b_n++;
      if (resp_c >= 0 || c >= 80) break;
      @(negedge clk);
      c++;
    end
    bus_idle();

    check("resp_seen", 32'(resp_c >= 0), 1);
    check("latency", resp_c, exp_lat);
    check("resp_rdata", g_rdata, wr ? 32'd0 : rd);
    check("resp_err", 32'(g_err), 32'(wr ? (br != 2'b00) : (rr != 2'b00)));
    check("req_ready_busy", 32'(ready_bad), 0);
    check("hs_counts", {ar_n[3:0], r_n[3:0], aw_n[3:0], w_n[3:0], b_n[3:0]},
          wr ? 20'h00111 : 20'h11000);
    if (wr) begin
      check("awaddr", g_awaddr, addr);
      check("awsize", 32'(g_awsize), 32'(exp_sz));
      check("wdata", g_wdata, wd);
      check("wstrb", 32'(g_wstrb), 32'(ws));
      check("wlast", 32'(g_wlast), 1);
      check("bready_early", 32'(bready_early), 0);
    end else begin
      check("araddr", g_araddr, addr);
      check("arsize", 32'(g_arsize), 32'(exp_sz));
      check("ar_stable", 32'(unstable), 0);
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 0);
    check("req_ready_after", 32'(req_ready), 1);
  endtask

  initial begin
    int wait_c;
    bit wr;
    logic [1:0] rr, br;
    #12;
    check("rst_outputs", {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, wlast, bready},
          8'h00);
    check("rst_payload", araddr | awaddr | wdata | resp_rdata | 32'(arsize) | 32'(wstrb), 0);
    check("rst_consts", {arid, awid, arlen, awlen, arburst, awburst}, {4'd1, 4'd1, 16'd0, 4'b0101});
    @(negedge clk); rst = 0;

    // Directed scenarios.
    do_txn(0, 32'h1FD0_F000, 2'd2, 4'hF, 32'h0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
    do_txn(1, 32'h1FAF_F002, 2'd0, 4'b0100, 32'h00AB_0000, 0, 0, 0, 2, 0, 0, 32'h0, 2'b00, 2'b00);
    do_txn(0, 32'h1FC0_0010, 2'd1, 4'hF, 32'h0, 5, 1, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 2'b00);
    do_txn(0, 32'h1F00_0004, 2'd2, 4'hF, 32'h0, 0, 2, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b10, 2'b00);
    do_txn(0, 32'h1F00_0008, 2'd3, 4'hF, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0BAD_CAFE, 2'b00, 2'b00);
    do_txn(1, 32'h1F00_0020, 2'd3, 4'hF, 32'h5555_AAAA, 0, 0, 2, 1, 0, 1, 32'h0, 2'b00, 2'b11);

    // Reset pulsed mid-read while waiting for rvalid.
    @(negedge clk);
    req_valid = 1; req_wr = 0; req_addr = 32'h1FD0_0040; req_size = 2'd2;
    @(negedge clk);
    req_valid = 0; arready = 1;
    wait_c = 0;
    while (!rready && wait_c < 10) begin @(negedge clk); wait_c++; end
    check("rready_before_rst", 32'(rready), 1);
    #1 rst = 1;
    #1;
    check("rst_async", {26'd0, rready, arvalid, resp_valid, req_ready, awvalid, wvalid}, 0);
    bus_idle();
    @(negedge clk); rst = 0;
    @(negedge clk); @(negedge clk);
    check("req_ready_after_rst", 32'(req_ready), 1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(wr, $urandom, 2'($urandom), 4'($urandom), $urandom,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom),
             $urandom, rr, br);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
